// File: rtl/joystick_scanner_pkg.sv
// Shared joystick definitions: chain protocol constants, scanner state
// encoding, serial bit-order constants and the sample-to-port unpacker.
// No ports; imported by joystick_scanner.
package joystick_scanner_pkg;

  // Joystick protocol: two DB9 sticks, six active-low buttons each.
  localparam int          JOY_W          = 6;
  localparam int          JOY_BITS       = 2 * JOY_W;
  localparam logic [5:0]  JOY_RELEASED   = 6'h3F;
  localparam logic [11:0] SAMPLE_RELEASE = 12'hFFF;

  // Scanner FSM encoding.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_SHIFT_LO = 3'd2;
  localparam logic [2:0] ST_SHIFT_HI = 3'd3;
  localparam logic [2:0] ST_COMPARE  = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  // Serial bit order: bits 0..5 are stick 1 (F2 first), 6..11 stick 2.
  localparam logic [3:0] BIT_JOY1_FIRST = 4'd0;
  localparam logic [3:0] BIT_JOY2_FIRST = 4'd6;
  localparam logic [3:0] BIT_LAST       = 4'd11;

  typedef struct packed {
    logic [JOY_W-1:0] joy2;
    logic [JOY_W-1:0] joy1;
  } joy_pair_t;

  // Serial bit k of a stick lands on port bit 5-k ({F2,F1,U,D,L,R}).
  function automatic joy_pair_t unpack_sample(input logic [11:0] s);
    joy_pair_t p;
    p.joy1 = {s[0], s[1], s[2], s[3],  s[4],  s[5]};
    p.joy2 = {s[6], s[7], s[8], s[9], s[10], s[11]};
    return p;
  endfunction

endpackage

// File: rtl/joystick_scanner_tick_divider.sv
// Free-running clock divider producing a one-clk tick every DIV cycles.
// Ports: clk (system clock), rst (sync active-high), tick (1-clk pulse).
module tick_divider #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/joystick_scanner.sv
// Scans two DB9 joysticks through a 12-bit 74HC165-style shift chain and
// publishes debounced button states (a sample must repeat on two
// consecutive scans before it reaches the outputs).
// Ports: clk, rst (sync active-high), enable (allows new scans),
//   joy_data (chain serial in), joy_load_n / joy_clk (chain strobes),
//   db9joy1 / db9joy2 ({F2,F1,U,D,L,R}, 0 = pressed),
//   scan_done (1-clk pulse per completed scan).
module joystick_scanner
  import joystick_scanner_pkg::*;
#(
  parameter int CLKDIV    = 16,
  parameter int GAP_TICKS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       joy_data,
  output logic       joy_load_n,
  output logic       joy_clk,
  output logic [5:0] db9joy1,
  output logic [5:0] db9joy2,
  output logic       scan_done
);

  logic        w_tick;
  logic [2:0]  r_state, w_next;
  logic [3:0]  r_bit_cnt;
  logic [9:0]  r_gap_cnt;
  logic [11:0] r_sample, r_prev;
  logic [5:0]  r_joy1, r_joy2;
  logic        r_load_n, r_jclk, r_done;
  logic        w_gap_last;
  joy_pair_t   w_pair;

  tick_divider #(.DIV(CLKDIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_gap_last = (r_gap_cnt == 10'(GAP_TICKS - 1));
  assign w_pair     = unpack_sample(r_sample);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_tick && enable) w_next = ST_LOAD;
      ST_LOAD:     if (w_tick) w_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_tick) w_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_tick) w_next = (r_bit_cnt == BIT_LAST) ? ST_COMPARE : ST_SHIFT_LO;
      ST_COMPARE:  w_next = ST_GAP;  // single clk, not tick-gated
      ST_GAP:      if (w_tick && w_gap_last) w_next = enable ? ST_LOAD : ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sample  <= SAMPLE_RELEASE;
      r_prev    <= SAMPLE_RELEASE;
      r_joy1    <= JOY_RELEASED;
      r_joy2    <= JOY_RELEASED;
      r_load_n  <= 1'b1;
      r_jclk    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_next;
      // Strobes are decoded from the next state so they flip on the same
      // edge as the state and are mutually exclusive by construction.
      r_load_n <= (w_next != ST_LOAD);
      r_jclk   <= (w_next == ST_SHIFT_HI);
      r_done   <= 1'b0;
      case (r_state)
        ST_LOAD:     if (w_tick) r_bit_cnt <= BIT_JOY1_FIRST;
        ST_SHIFT_LO: if (w_tick) r_sample[r_bit_cnt] <= joy_data;
        ST_SHIFT_HI: if (w_tick && r_bit_cnt != BIT_LAST) r_bit_cnt <= r_bit_cnt + 1'b1;
        ST_COMPARE: begin
          if (r_sample == r_prev) begin
            r_joy1 <= w_pair.joy1;
            r_joy2 <= w_pair.joy2;
          end
          r_prev    <= r_sample;
          r_done    <= 1'b1;
          r_bit_cnt <= '0;
        end
        ST_GAP: if (w_tick) r_gap_cnt <= w_gap_last ? 10'd0 : r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign joy_load_n = r_load_n;
  assign joy_clk    = r_jclk;
  assign db9joy1    = r_joy1;
  assign db9joy2    = r_joy2;
  assign scan_done  = r_done;

endmodule

// File: tb/tb_joystick_scanner.sv
module tb_joystick_scanner;
  localparam int CLKDIV = 16;
  localparam int GAP    = 4;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic joy_data, joy_load_n, joy_clk, scan_done;
  logic [5:0] db9joy1, db9joy2;

  int checks = 0, failures = 0;

  joystick_scanner #(.CLKDIV(CLKDIV), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .joy_data(joy_data),
    .joy_load_n(joy_load_n), .joy_clk(joy_clk),
    .db9joy1(db9joy1), .db9joy2(db9joy2), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Behavioural 74HC165 chain: parallel load while load_n low, shift on
  // joy_clk rising; word is presented MSB first.
  logic [11:0] chain_word = 12'hFFF, chain_sh = 12'hFFF;
  logic        chain_prev_jc = 1'b0;
  always @(posedge clk) begin
    if (joy_load_n === 1'b0) chain_sh <= chain_word;
    else if (joy_clk === 1'b1 && !chain_prev_jc) chain_sh <= {chain_sh[10:0], 1'b1};
    chain_prev_jc <= (joy_clk === 1'b1);
  end
  assign joy_data = chain_sh[11];

  // Waveform monitor, sampled 1 time unit after each rising edge.
  int lat_cnt = 0, last_lat = 0, rises = 0, last_rises = 0, load_falls = 0;
  int done_cnt = 0, ln_run = 0, ln_width = 0, jc_run = 0, jc_width = 0;
  int last_period = 0, overlap = 0;
  logic prev_ln = 1'b1, prev_jc = 1'b0;
  always @(posedge clk) begin
    #1;
    if (prev_ln === 1'b1 && joy_load_n === 1'b0) begin
      last_period = lat_cnt + 1;
      lat_cnt = 0; rises = 0; load_falls++;
    end else lat_cnt++;
    if (joy_load_n === 1'b0) ln_run++;
    else begin
      if (prev_ln === 1'b0) ln_width = ln_run;
      ln_run = 0;
    end
    if (joy_clk === 1'b1) begin
      if (prev_jc !== 1'b1) rises++;
      jc_run++;
    end else begin
      if (prev_jc === 1'b1) jc_width = jc_run;
      jc_run = 0;
    end
    if (scan_done === 1'b1) begin last_lat = lat_cnt; last_rises = rises; done_cnt++; end
    if (joy_load_n === 1'b0 && joy_clk === 1'b1) overlap++;
    prev_ln = joy_load_n;
    prev_jc = joy_clk;
  end

  // Reference: outputs take a sample only when it repeats the previous one.
  // With MSB-first chain order, stick 1 is word[11:6] and stick 2 word[5:0].
  logic [11:0] m_prev = 12'hFFF, m_out = 12'hFFF;
  task automatic model_reset();
    m_prev = 12'hFFF; m_out = 12'hFFF;
  endtask
  task automatic model_scan(input logic [11:0] w);
    if (w == m_prev) m_out = w;
    m_prev = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_joy1"}, {26'd0, db9joy1}, {26'd0, m_out[11:6]});
    chk({tag, "_joy2"}, {26'd0, db9joy2}, {26'd0, m_out[5:0]});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (scan_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, {31'd0, scan_done}, 32'd1);
  endtask

  task automatic wait_rises(input int r, input string tag);
    int n = 0;
    int f0 = load_falls;
    @(negedge clk);
    while (!(load_falls != f0 && rises >= r) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_rise_seen"}, rises, r);
  endtask

  initial begin
    logic [11:0] w;
    int bad, f0, d0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_load_n", {31'd0, joy_load_n}, 32'd1);
    chk("rst_jclk",   {31'd0, joy_clk},    32'd0);
    chk("rst_joy1",   {26'd0, db9joy1},    32'h3F);
    chk("rst_joy2",   {26'd0, db9joy2},    32'h3F);
    chk("rst_done",   {31'd0, scan_done},  32'd0);
    rst = 1'b0;

    // Idle with enable low
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (joy_load_n !== 1'b1 || joy_clk !== 1'b0 || scan_done !== 1'b0 ||
          db9joy1 !== 6'h3F || db9joy2 !== 6'h3F) bad++;
    end
    chk("idle_bad_cycles", bad, 0);
    chk("idle_no_load", load_falls, 0);

    // Two identical scans of 0111_1111_1110
    chain_word = 12'b0111_1111_1110;
    enable = 1'b1;
    wait_done("scan1");
    model_scan(chain_word);
    chk("scan1_joy1", {26'd0, db9joy1}, 32'h3F);
    chk("scan1_joy2", {26'd0, db9joy2}, 32'h3F);
    chk("load_width",  ln_width, CLKDIV);
    chk("jclk_width",  jc_width, CLKDIV);
    chk("scan_latency", last_lat, 25 * CLKDIV + 1);
    chk("jclk_rises",  last_rises, 12);
    wait_done("scan2");
    model_scan(chain_word);
    chk("scan2_joy1", {26'd0, db9joy1}, 32'h1F);
    chk("scan2_joy2", {26'd0, db9joy2}, 32'h3E);

    // Random words, roughly half repeating the previous one
    w = chain_word;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 0) w = 12'($urandom_range(0, 4095));
      chain_word = w;
      wait_done($sformatf("rand%0d", i));
      model_scan(w);
      check_outs($sformatf("rand%0d", i));
    end
    chk("load_period", last_period, (25 + GAP) * CLKDIV);

    // Reset in SHIFT_HI of bit 7
    chain_word = 12'($urandom_range(0, 4095));
    wait_rises(8, "midrst");
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_load_n", {31'd0, joy_load_n}, 32'd1);
    chk("midrst_jclk",   {31'd0, joy_clk},    32'd0);
    chk("midrst_joy1",   {26'd0, db9joy1},    32'h3F);
    chk("midrst_joy2",   {26'd0, db9joy2},    32'h3F);
    chk("midrst_done",   {31'd0, scan_done},  32'd0);
    d0 = done_cnt;
    chain_word = 12'hFFF;
    model_reset();
    rst = 1'b0;
    wait_done("postrst");
    chk("postrst_done_cnt", done_cnt, d0 + 1);
    chk("postrst_latency", last_lat, 25 * CLKDIV + 1);
    chk("postrst_rises", last_rises, 12);
    model_scan(12'hFFF);
    check_outs("postrst");

    // Alternating all-released / all-pressed never reaches the outputs
    for (int i = 0; i < 6; i++) begin
      w = (i % 2 == 0) ? 12'h000 : 12'hFFF;
      chain_word = w;
      wait_done($sformatf("alt%0d", i));
      model_scan(w);
      chk($sformatf("alt%0d_joy1", i), {26'd0, db9joy1}, 32'h3F);
      chk($sformatf("alt%0d_joy2", i), {26'd0, db9joy2}, 32'h3F);
    end

    // Drop enable during bit 3: scan finishes, then FSM parks
    chain_word = 12'($urandom_range(0, 4095));
    wait_rises(4, "endrop");
    enable = 1'b0;
    wait_done("endrop");
    model_scan(chain_word);
    check_outs("endrop");
    f0 = load_falls;
    d0 = done_cnt;
    repeat (1500) @(negedge clk);
    chk("endrop_no_load", load_falls, f0);
    chk("endrop_no_done", done_cnt, d0);
    chk("endrop_load_n", {31'd0, joy_load_n}, 32'd1);
    chk("endrop_jclk",   {31'd0, joy_clk},    32'd0);

    chk("strobe_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
